// File: rtl/dispatch_buffer_pkg.sv
// Shared types for the decode-to-core dispatch buffer.
// Entry layout, per-cycle count type and stall counter ceiling.
package dispatch_buffer_pkg;

    localparam int DISP_WIDTH     = 4;
    localparam int DISP_PAYLOAD_W = 128;
    localparam int DISP_CNT_W     = $clog2(DISP_WIDTH + 1);

    localparam logic [31:0] DISP_STALL_MAX = 32'hFFFF_FFFF;

    typedef logic [DISP_CNT_W-1:0] dispatch_cnt_t;

    typedef struct packed {
        logic [DISP_PAYLOAD_W-1:0] payload;
        logic                      is_store;
    } dispatch_entry_t;

endpackage

// File: rtl/dispatch_select.sv
// Longest in-order prefix of a dispatch window that fits ROB/RS credits
// and whose store count fits the SQ credit.
module dispatch_select #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] win_store,
    input  logic [CNT_W-1:0] avail,
    input  logic [CNT_W-1:0] rob_free,
    input  logic [CNT_W-1:0] rs_free,
    input  logic [CNT_W-1:0] sq_free,
    output logic [CNT_W-1:0] d
);

    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] st_n;
    logic             ok;

    always_comb begin
        lim = avail;
        if (rob_free < lim) lim = rob_free;
        if (rs_free < lim)  lim = rs_free;
        d    = '0;
        st   = '0;
        st_n = '0;
        ok   = 1'b1;
        // a store without an SQ slot blocks itself and everything younger
        for (int i = 0; i < WIDTH; i++) begin
            if (ok && (CNT_W'(i) < lim)) begin
                st_n = st + CNT_W'(win_store[i]);
                if (st_n <= sq_free) begin
                    d  = CNT_W'(i + 1);
                    st = st_n;
                end else begin
                    ok = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order circular dispatch queue between decode and the OoO core.
// Optional same-cycle bypass on an empty queue: DISPATCH_BYPASS_EN.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = DISP_PAYLOAD_W,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic [WIDTH-1:0]              in_valid,
    input  logic [WIDTH*PAYLOAD_W-1:0]    in_payload,
    input  logic [WIDTH-1:0]              in_is_store,
    output logic [CNT_W-1:0]              in_accept_cnt,
    input  logic [CNT_W-1:0]              rob_free,
    input  logic [CNT_W-1:0]              rs_free,
    input  logic [CNT_W-1:0]              sq_free,
    output logic [WIDTH-1:0]              out_valid,
    output logic [WIDTH*PAYLOAD_W-1:0]    out_payload,
    output logic [WIDTH-1:0]              out_is_store,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy,
    output logic [31:0]                   stall_cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    dispatch_entry_t  entries_q [DEPTH];
    dispatch_entry_t  entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [31:0]      stall_q, stall_d;

    dispatch_entry_t  lane_ent [WIDTH];
    dispatch_entry_t  win [WIDTH];
    logic [WIDTH-1:0] win_store;
    logic [CNT_W-1:0] pre_len, acc, avail, sel_avail;
    logic [CNT_W-1:0] d_raw, d, wr_cnt, wr_start;
    logic [OCC_W-1:0] free_slots;
    logic             block, byp, run;

    assign block = reset | squash;

`ifdef DISPATCH_BYPASS_EN
    assign byp = (count_q == '0);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        pre_len = '0;
        run     = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (run && in_valid[i]) pre_len = pre_len + CNT_W'(1);
            else                    run = 1'b0;
        end
        // free space uses start-of-cycle count to avoid a loop through d
        free_slots = OCC_W'(DEPTH) - count_q;
        if (block)                              acc = '0;
        else if (OCC_W'(pre_len) <= free_slots) acc = pre_len;
        else                                    acc = CNT_W'(free_slots);
        if (count_q >= OCC_W'(WIDTH)) avail = CNT_W'(WIDTH);
        else                          avail = CNT_W'(count_q);
        sel_avail = byp ? acc : avail;
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            lane_ent[i].payload  = DISP_PAYLOAD_W'(in_payload[i*PAYLOAD_W +: PAYLOAD_W]);
            lane_ent[i].is_store = in_is_store[i];
            win[i]       = byp ? lane_ent[i] : entries_q[head_q + PTR_W'(i)];
            win_store[i] = win[i].is_store;
        end
    end

    dispatch_select #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_select (
        .win_store (win_store),
        .avail     (sel_avail),
        .rob_free  (rob_free),
        .rs_free   (rs_free),
        .sq_free   (sq_free),
        .d         (d_raw)
    );

    assign d = block ? '0 : d_raw;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            out_valid[i]    = CNT_W'(i) < d;
            out_is_store[i] = out_valid[i] & win[i].is_store;
            out_payload[i*PAYLOAD_W +: PAYLOAD_W] =
                out_valid[i] ? win[i].payload[PAYLOAD_W-1:0] : '0;
        end
    end

    always_comb begin
        wr_start  = byp ? d : '0;
        wr_cnt    = acc - wr_start;
        entries_d = entries_q;
        for (int i = 0; i < WIDTH; i++) begin
            if ((CNT_W'(i) >= wr_start) && (CNT_W'(i) < acc)) begin
                entries_d[tail_q + PTR_W'(i) - PTR_W'(wr_start)] = lane_ent[i];
            end
        end
        head_d  = head_q + (byp ? '0 : PTR_W'(d));
        tail_d  = tail_q + PTR_W'(wr_cnt);
        count_d = count_q + OCC_W'(acc) - OCC_W'(d);
        stall_d = stall_q;
        if ((count_q != '0) && (d == '0) && (stall_q != DISP_STALL_MAX)) begin
            stall_d = stall_q + 32'd1;
        end
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    always_ff @(posedge clock) begin
        entries_q <= entries_d;
    end

    assign in_accept_cnt = acc;
    assign occupancy     = count_q;
    assign stall_cycles  = stall_q;

endmodule

// File: doc/dispatch_buffer.md
# dispatch_buffer

Parametrised in-order dispatch queue between decode and the out-of-order core (RS/ROB/SQ/RAT).
- Today a structural hazard stalls the whole decode group. This block instead buffers decoded instructions in a circular queue.
- Each cycle it releases the longest in-order prefix that fits the free capacity reported by the ROB, the RS and the SQ, so groups can be dispatched partially.
- It absorbs squashes and counts dispatch-stall cycles for performance analysis.

## Interface
Parameters:
- WIDTH, 4: instructions per cycle on both the input and output sides.
- DEPTH, 8: queue entries; must be a power of two and at least WIDTH.
- PAYLOAD_W, 128: bits of opaque decoded-instruction payload per entry.
- CNT_W, $clog2(WIDTH+1): width of all per-cycle count signals.

Ports (reset is synchronous and active-high on `clock`; one clock domain):
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- squash  in  1  flush all entries (mispredict from ROB commit).
- in_valid  in  WIDTH  decode lane valids; only the contiguous prefix from lane 0 is considered.
- in_payload  in  WIDTH*PAYLOAD_W  decoded instructions; lane 0 is oldest.
- in_is_store  in  WIDTH  lane carries a store and consumes one SQ slot.
- in_accept_cnt  out  CNT_W  number of leading lanes captured this cycle.
- rob_free  in  CNT_W  ROB slots available this cycle, saturated at WIDTH.
- rs_free  in  CNT_W  RS slots available this cycle, saturated at WIDTH.
- sq_free  in  CNT_W  SQ slots available this cycle, saturated at WIDTH.
- out_valid  out  WIDTH  dispatch lane valids; always a prefix (thermometer code).
- out_payload  out  WIDTH*PAYLOAD_W  dispatched instructions; lane 0 is oldest.
- out_is_store  out  WIDTH  store flag for each dispatched lane.
- occupancy  out  $clog2(DEPTH+1)  valid entries held.
- stall_cycles  out  32  saturating count of stalled cycles.

## Operation
- State: head, tail (each $clog2(DEPTH) bits, wrap mod DEPTH), count, entry array, stall_cycles.
- Accept: in_accept_cnt = min(prefix length of in_valid, DEPTH − count). Use count at the start of the cycle, not freed-this-cycle space; this keeps the path free of combinational feedback. Accepted lanes are written at tail, tail+1, … mod DEPTH.
- Dispatch: d = largest k ≤ min(count, WIDTH, rob_free, rs_free) such that stores among entries head..head+k−1 ≤ sq_free.
  - Dispatch is strictly in order: a store that lacks an SQ slot blocks everything younger than it.
  - out_valid[i] = (i < d); out_payload[i] = entry[head+i mod DEPTH].
- The consumer takes all valid output lanes unconditionally. The credits are the handshake.
- Update: head += d; tail += in_accept_cnt; count += in_accept_cnt − d. Simultaneous accept and dispatch on the same slots at full occupancy is legal.
- stall_cycles increments when count > 0 and d == 0, and saturates at 2^32−1. It is not cleared by squash.
- Squash: head, tail and count go to 0 on the next edge. Same-cycle inputs are dropped, so in_accept_cnt = 0. out_valid = 0 during the squash cycle.
- Reset: head = tail = count = 0, stall_cycles = 0. Entry contents are don't-care.

## Timing
- Minimum latency from input to output is 1 cycle: an instruction accepted at edge t can appear on out_valid in the cycle after edge t.
- in_accept_cnt, out_valid, out_payload and out_is_store are combinational from state, inputs and credits. They are 0 while reset or squash is high.
- Outputs after reset: in_accept_cnt = 0 while reset is high, then up to WIDTH. occupancy = 0, stall_cycles = 0, out_valid = 0.
- Credit inputs must be stable in-cycle. Credits above WIDTH are a protocol error and are not checked.

## Configuration
- DISPATCH_BYPASS_EN defined: when count == 0, accepted lanes may dispatch in the same cycle.
  - d is computed over the incoming prefix under the same credit and store rules.
  - Only the undispatched remainder is written; latency is 0.
- Undefined: the 1-cycle minimum latency holds strictly.

## Structure
- Shared package:
  - DISPATCH_ENTRY struct (payload, is_store).
  - DISPATCH_CNT typedef.
  - Saturation constant for stall_cycles.
- One sub-module, dispatch_select: combinational computation of d from the head window, the credits and the store prefix count. It is reused for the bypass path.

## Test plan
- Reset, then 4 valid lanes with all credits = 4 → in_accept_cnt = 4; next cycle out_valid = 4'b1111, occupancy 0 after dispatch.
- rob_free = 2 with 6 buffered → out_valid = 4'b0011, occupancy 6→4; stall_cycles unchanged.
- Head window [alu, st, st, alu] with sq_free = 1 → out_valid = 4'b0011; the second store and the alu behind it are held.
- Fill to DEPTH = 8 with no credits, offer 4 lanes → in_accept_cnt = 0; stall_cycles +1 per cycle; head/tail wrap correctly after refill past index 7.
- Squash asserted with occupancy 5 and in_valid = 4'b1111 → in_accept_cnt = 0, next cycle occupancy 0 and out_valid = 0; stall_cycles retained.
- With DISPATCH_BYPASS_EN, empty queue, 3 lanes, all credits = 4 → out_valid = 4'b0111 in the same cycle, occupancy stays 0.
